opc_prefetch: RTL
=================

Name: opc_prefetch

Overview:
- Instruction fetch stage of the VM1 core. Sits directly upstream of the instruction decoder.
- Issues word reads at the fetch PC over a req/ack bus handshake and buffers fetched words in a small FIFO.
- Presents the head word as idc_opc with a valid/take handshake.
- Supports redirect (flush) on branches, jumps and traps, and records bus faults.

Parameters:
- DEPTH, 2, number of prefetch FIFO entries (power of two, 2..4).
- RESET_PC, 16'o100000, fetch PC loaded at reset.

Ports:
- m_clock  in  1  system clock, rising edge.
- p_reset  in  1  asynchronous active-low reset.
- fetch_en  in  1  permits new bus requests; an in-flight request always completes.
- flush  in  1  redirect: discard the queue and restart fetch at flush_pc.
- flush_pc  in  16  new fetch address; bit 0 is ignored (forced 0).
- bus_req  out  1  read request, held until bus_ack.
- bus_addr  out  16  word address of the request; stable while bus_req is high.
- bus_ack  in  1  one-cycle read completion; bus_din is valid in the same cycle.
- bus_err  in  1  one-cycle completion with fault instead of data (may coincide with bus_ack; err wins).
- bus_din  in  16  read data.
- idc_opc  out  16  head opcode word, to the decoder.
- opc_pc  out  16  address the head word was fetched from.
- opc_valid  out  1  head entry present.
- opc_take  in  1  decoder consumes head; ignored when opc_valid=0.
- fetch_fault  out  1  sticky bus-fault flag.
- fault_pc  out  16  address of the faulting fetch.

Behaviour:
- Reset values:
  - fpc=RESET_PC, FIFO empty.
  - bus_req=0, bus_addr=RESET_PC.
  - opc_valid=0, idc_opc=0, opc_pc=0.
  - fetch_fault=0, fault_pc=0, state=IDLE.
- Reset mid-transaction drops bus_req immediately. The bus is responsible for dropping a stale ack after reset.
- FIFO holds {opc, pc} pairs; occupancy counter is 0..DEPTH.
- idc_opc/opc_pc are driven combinationally from the head entry. When empty they hold their last value (0 after reset).
- State machine:
  - IDLE -> REQ when fetch_en & !fetch_fault & !flush & (count + pending) < DEPTH. On this transition bus_req=1 and bus_addr=fpc are registered.
  - REQ, on ack without err and no flush that cycle:
    - Push {bus_din, bus_addr}; fpc += 2 (wraps 16'o177776 -> 0).
    - Go to IDLE, bus_req=0.
    - Next request starts no earlier than the following cycle, so minimum issue spacing is 2 cycles.
  - REQ, on err: set fetch_fault=1, fault_pc=bus_addr; no push; go to IDLE. Further requests are blocked until flush.
  - REQ, on flush with no ack this cycle: go to DROP. bus_req stays high, because a request is never withdrawn before ack.
  - REQ, on flush and ack in the same cycle: the data is discarded; go to IDLE.
  - DROP: wait for ack or err, discard the result without setting the fault, go to IDLE. A further flush in DROP only updates fpc.
- Flush, in any state:
  - Same cycle: FIFO cleared, fpc <= {flush_pc[15:1], 0}, fetch_fault cleared.
  - opc_valid=0 the next cycle. opc_take in the flush cycle is ignored.
- Latency from flush, with a zero-wait bus (ack one cycle after req is seen): req at cycle +1, ack at +2, opc_valid at +3.
- Simultaneous push and take while full: legal only as take-then-push. The issue condition already prevents overflow.
- Push and take in the same cycle leave the count unchanged.
- Take while empty: no effect. FIFO pointers wrap modulo DEPTH.
- Backpressure: while count=DEPTH and no take, no new request is issued.

Decomposition:
- Shared package cpu_pkg:
  - fetch state encoding (IDLE=2'd0, REQ=2'd1, DROP=2'd2);
  - VM1_RESET_PC=16'o100000;
  - the WORD width constant 16.
- One sub-module, opc_fifo (parameter DEPTH, WIDTH=32):
  - ports: push, pop, clear, din, dout, count, empty, full;
  - single-cycle clear, same async active-low reset.
- The top level holds the FSM, fpc, and the fault logic.

Test Plan:
- Reset release, fetch_en=1, bus acks each req next cycle with bus_din=16'o012737 then 16'o000240:
  - first bus_addr=16'o100000, second 16'o100002;
  - opc_valid rises 3 cycles after reset release with idc_opc=16'o012737, opc_pc=16'o100000.
- Decoder holds opc_take=0:
  - exactly DEPTH=2 words are fetched, then bus_req stays 0;
  - one take produces exactly one new request at the next sequential address.
- Flush to flush_pc=16'o001001 while REQ is outstanding at 16'o100004, ack arrives 3 cycles later with 16'o177777:
  - that word is never visible;
  - the next request is at 16'o001000;
  - opc_valid=0 from the cycle after flush until new data arrives.
- bus_err on the fetch at 16'o100010:
  - fetch_fault=1, fault_pc=16'o100010;
  - earlier buffered words are still delivered; no further bus_req;
  - flush to 16'o000000 clears the fault and restarts fetch.
- Sequential fetch from 16'o177776:
  - the next bus_addr wraps to 16'o000000;
  - the entry carries opc_pc=16'o177776.
- p_reset asserted while bus_req=1 and FIFO full:
  - bus_req, opc_valid and fetch_fault go to 0 asynchronously (before the next edge);
  - after release, fetch restarts at 16'o100000.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared VM1 core constants, fetch state encoding and fetch entry layout
package cpu_pkg;

    localparam int WORD = 16;
    localparam logic [WORD-1:0] VM1_RESET_PC = 16'o100000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [WORD-1:0] opc;
        logic [WORD-1:0] pc;
    } fetch_entry_t;

    function automatic logic [WORD-1:0] word_align(input logic [WORD-1:0] addr);
        return {addr[WORD-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/opc_fifo.sv
// rtl/opc_fifo.sv - small ring-buffer FIFO holding fetched {opc, pc} entries
module opc_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             m_clock,
    input  logic             p_reset,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge m_clock) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/opc_prefetch.sv
// rtl/opc_prefetch.sv - VM1 instruction prefetch: bus fetch FSM, fetch PC, fault capture, opcode queue
module opc_prefetch
    import cpu_pkg::*;
#(
    parameter int              DEPTH    = 2,
    parameter logic [WORD-1:0] RESET_PC = VM1_RESET_PC
) (
    input  logic            m_clock,
    input  logic            p_reset,
    input  logic            fetch_en,
    input  logic            flush,
    input  logic [WORD-1:0] flush_pc,
    output logic            bus_req,
    output logic [WORD-1:0] bus_addr,
    input  logic            bus_ack,
    input  logic            bus_err,
    input  logic [WORD-1:0] bus_din,
    output logic [WORD-1:0] idc_opc,
    output logic [WORD-1:0] opc_pc,
    output logic            opc_valid,
    input  logic            opc_take,
    output logic            fetch_fault,
    output logic [WORD-1:0] fault_pc
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [WORD-1:0] fpc;
    logic            issue;
    logic            push;
    logic            pop;
    logic            fault_set;
    logic [CW-1:0]   count;
    logic            empty;
    logic            full;
    logic [2*WORD-1:0] fifo_dout;
    fetch_entry_t    head;
    fetch_entry_t    hold;
    fetch_entry_t    entry_in;

    // Nothing is in flight while IDLE, so room in the queue is simply "not full"
    assign issue = (state == IDLE) && fetch_en && !fetch_fault && !flush && !full;
    assign pop   = opc_take && !flush;

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (issue) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (bus_ack || bus_err) begin
                    state_next = IDLE;
                end else if (flush) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (bus_ack || bus_err) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A request is never withdrawn: DROP keeps bus_req high and just discards the result
    always_comb begin
        bus_req   = (state == REQ) || (state == DROP);
        push      = (state == REQ) && bus_ack && !bus_err && !flush;
        fault_set = (state == REQ) && bus_err && !flush;
    end

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            fpc         <= RESET_PC;
            bus_addr    <= RESET_PC;
            fetch_fault <= 1'b0;
            fault_pc    <= '0;
            hold        <= '0;
        end else begin
            if (issue) begin
                bus_addr <= fpc;
            end
            if (flush) begin
                fpc <= word_align(flush_pc);
            end else if (push) begin
                fpc <= fpc + WORD'(2);
            end
            if (flush) begin
                fetch_fault <= 1'b0;
            end else if (fault_set) begin
                fetch_fault <= 1'b1;
                fault_pc    <= bus_addr;
            end
            if (!empty) begin
                hold <= head;
            end
        end
    end

    always_comb begin
        entry_in     = '0;
        entry_in.opc = bus_din;
        entry_in.pc  = bus_addr;
    end

    opc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * WORD)
    ) u_fifo (
        .m_clock (m_clock),
        .p_reset (p_reset),
        .push    (push),
        .pop     (pop),
        .clear   (flush),
        .din     (entry_in),
        .dout    (fifo_dout),
        .count   (count),
        .empty   (empty),
        .full    (full)
    );

    assign head      = fetch_entry_t'(fifo_dout);
    assign opc_valid = (count != '0);
    // The decoder-facing word keeps its last value while the queue is empty
    assign idc_opc   = empty ? hold.opc : head.opc;
    assign opc_pc    = empty ? hold.pc  : head.pc;

endmodule
